mem_arb: RTL and testbench

- Two-requester arbiter that shares one memory port between the CPU instruction-fetch path (ifu, read-only) and the load/store path (lsu, read/write).
- Sits between the cpu top and the single SoC memory/bus slave.
- Sequences one transaction at a time and captures the request fields.
- Routes the response back only to the requester that owns the transaction.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_sel.sv | 30 +++
 rtl/mem_arb.sv | 133 +++++++++++++
 tb/tb_mem_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// requester ids and the fixed fetch access size.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IFU = 2'd1,
        ARB_BUSY_LSU = 2'd2
    } arb_state_t;

    localparam logic       REQ_IFU   = 1'b0;
    localparam logic       REQ_LSU   = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Busy state that corresponds to a granted requester id.
    function automatic arb_state_t busy_state(input logic id);
        return (id == REQ_LSU) ? ARB_BUSY_LSU : ARB_BUSY_IFU;
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant select. Fixed LSU priority by default; round-robin on
// ties when MEM_ARB_RR_EN is defined.
module mem_arb_sel
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic last_grant,
`endif
    input  logic ifu_req,
    input  logic lsu_req,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = ifu_req | lsu_req;
        grant_id    = REQ_IFU;
        if (ifu_req && lsu_req) begin
`ifdef MEM_ARB_RR_EN
            // On a tie, the requester not served last time goes first.
            grant_id = (last_grant == REQ_IFU) ? REQ_LSU : REQ_IFU;
`else
            grant_id = REQ_LSU;
`endif
        end else if (lsu_req) begin
            grant_id = REQ_LSU;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory port between instruction fetch (read-only) and load/store.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_reqValid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [1:0]          lsu_size,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_reqValid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [1:0]          mem_size,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_respValid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state_reg, state_next;
    logic       grant_valid;
    logic       grant_id;
    logic       capture;
    logic       resp_ifu;
    logic       resp_lsu;

`ifdef MEM_ARB_RR_EN
    logic       last_grant_reg;
`endif

    mem_arb_sel u_sel (
`ifdef MEM_ARB_RR_EN
        .last_grant  (last_grant_reg),
`endif
        .ifu_req     (ifu_reqValid),
        .lsu_req     (lsu_reqValid),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (grant_valid) begin
                    capture    = 1'b1;
                    state_next = busy_state(grant_id);
                end
            end
            ARB_BUSY_IFU, ARB_BUSY_LSU: begin
                if (mem_respValid) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request fields are latched only at grant, so requester inputs are free
    // to change for the rest of the transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_reqValid <= 1'b0;
            mem_addr     <= '0;
            mem_size     <= '0;
            mem_wen      <= 1'b0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
        end else if (capture) begin
            mem_reqValid <= 1'b1;
            if (grant_id == REQ_LSU) begin
                mem_addr  <= lsu_addr;
                mem_size  <= lsu_size;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
            end else begin
                mem_addr  <= ifu_addr;
                mem_size  <= SIZE_WORD;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end
        end else if (state_reg != ARB_IDLE && mem_respValid) begin
            mem_reqValid <= 1'b0;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_reg <= REQ_IFU;
        end else if (capture) begin
            last_grant_reg <= grant_id;
        end
    end
`endif

    // A response in IDLE (e.g. stale after reset) matches no owner and is dropped.
    assign resp_ifu = (state_reg == ARB_BUSY_IFU) && mem_respValid;
    assign resp_lsu = (state_reg == ARB_BUSY_LSU) && mem_respValid;

    assign ifu_respValid = resp_ifu;
    assign lsu_respValid = resp_lsu;
    assign ifu_rdata     = resp_ifu ? mem_rdata : '0;
    assign lsu_rdata     = resp_lsu ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a transaction-level reference model checked
// every cycle; honours MEM_ARB_RR_EN for the expected tie order.
module tb_mem_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ifu_reqValid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [1:0]  lsu_size = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 ifu, 2 lsu) and the
    // request record that was handed downstream.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    int   m_owner;
    int   m_last;
    req_t m_req;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_owner <= 0;
            m_last  <= 1;
            m_req   <= '0;
        end else if (m_owner == 0) begin
            if (ifu_reqValid || lsu_reqValid) begin
                int who;
                if (ifu_reqValid && lsu_reqValid) begin
`ifdef MEM_ARB_RR_EN
                    who = (m_last == 1) ? 2 : 1;
`else
                    who = 2;
`endif
                end else begin
                    who = lsu_reqValid ? 2 : 1;
                end
                m_owner <= who;
                m_last  <= who;
                if (who == 2) m_req <= '{lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask};
                else          m_req <= '{ifu_addr, 2'b10, 1'b0, 32'h0, 4'h0};
            end
        end else if (mem_respValid) begin
            m_owner <= 0;
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            logic e_ifu, e_lsu;
            e_ifu = (m_owner == 1) && mem_respValid;
            e_lsu = (m_owner == 2) && mem_respValid;
            check("model mem_reqValid", mem_reqValid, m_owner != 0);
            if (m_owner != 0) begin
                check("model mem_addr",  mem_addr,  m_req.addr);
                check("model mem_size",  mem_size,  m_req.size);
                check("model mem_wen",   mem_wen,   m_req.wen);
                check("model mem_wdata", mem_wdata, m_req.wdata);
                check("model mem_wmask", mem_wmask, m_req.wmask);
            end
            check("model ifu_respValid", ifu_respValid, e_ifu);
            check("model lsu_respValid", lsu_respValid, e_lsu);
            check("model ifu_rdata", ifu_rdata, e_ifu ? mem_rdata : 32'h0);
            check("model lsu_rdata", lsu_rdata, e_lsu ? mem_rdata : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Poll for the downstream request, bounded; then pin its address.
    task automatic wait_grant(input string name, input logic [31:0] exp_addr);
        bit ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_reqValid) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " grant seen"}, ok, 1'b1);
        check({name, " mem_addr"}, mem_addr, exp_addr);
        $display("[TB] %s: granted addr=%08h wen=%0b", name, mem_addr, mem_wen);
    endtask

    // Respond after wait_n cycles; check the routed pulse and drop requests.
    task automatic serve(input string name, input int wait_n, input logic [31:0] data,
                         input bit to_lsu, input bit drop_ifu, input bit drop_lsu);
        repeat (wait_n) tick();
        mem_respValid = 1'b1;
        mem_rdata     = data;
        @(negedge clock);
        check({name, " ifu_respValid"}, ifu_respValid, !to_lsu);
        check({name, " lsu_respValid"}, lsu_respValid, to_lsu);
        check({name, " owner rdata"}, to_lsu ? lsu_rdata : ifu_rdata, data);
        check({name, " other rdata"}, to_lsu ? ifu_rdata : lsu_rdata, 32'h0);
        $display("[TB] %s: response %08h to %s", name, data, to_lsu ? "lsu" : "ifu");
        tick();
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        if (drop_ifu) ifu_reqValid = 1'b0;
        if (drop_lsu) lsu_reqValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a response pulse present to show outputs stay quiet.
        #1 reset = 1'b1;
        mem_respValid = 1'b1;
        mem_rdata     = 32'hFFFF_FFFF;
        @(posedge clock);
        checking = 1'b1;
        @(negedge clock);
        check("reset mem_reqValid", mem_reqValid, 1'b0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset ifu_respValid", ifu_respValid, 1'b0);
        check("reset lsu_rdata", lsu_rdata, 32'h0);
        $display("[TB] reset: mem_reqValid=%0b", mem_reqValid);
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        @(posedge clock);
        #1 reset = 1'b0;

        // Single IFU fetch.
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0000;
        wait_grant("ifu fetch", 32'h8000_0000);
        check("ifu fetch mem_wen", mem_wen, 1'b0);
        check("ifu fetch mem_wmask", mem_wmask, 4'h0);
        check("ifu fetch mem_size", mem_size, 2'b10);
        serve("ifu fetch", 2, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("ifu fetch bubble", mem_reqValid, 1'b0);

        // LSU store with a long response wait.
        tick();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h8000_0104;
        lsu_size     = 2'b10;
        lsu_wen      = 1'b1;
        lsu_wdata    = 32'h0000_AB00;
        lsu_wmask    = 4'b0010;
        wait_grant("lsu store", 32'h8000_0104);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clock);
            check("store hold valid", mem_reqValid, 1'b1);
            check("store hold wen", mem_wen, 1'b1);
            check("store hold wdata", mem_wdata, 32'h0000_AB00);
            check("store hold wmask", mem_wmask, 4'b0010);
        end
        serve("lsu store", 1, 32'h0, 1'b1, 1'b0, 1'b1);
        lsu_wen   = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = '0;

        // Simultaneous request from reset: LSU first, then IFU after a bubble.
        do_reset();
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h0000_1000;
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0000_2000;
        wait_grant("tie first", 32'h0000_2000);
        serve("tie first", 2, 32'h0000_0055, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        check("tie bubble", mem_reqValid, 1'b0);
        wait_grant("tie second", 32'h0000_1000);
        serve("tie second", 1, 32'h0000_0066, 1'b0, 1'b1, 1'b0);

        // Both held across four transactions: tie order.
        do_reset();
        ifu_reqValid = 1'b1;
        lsu_reqValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit exp_lsu;
`ifdef MEM_ARB_RR_EN
            exp_lsu = (k % 2) == 0;
`else
            exp_lsu = 1'b1;
`endif
            wait_grant("held tie", exp_lsu ? 32'h0000_2000 : 32'h0000_1000);
            serve("held tie", 1, 32'h100 + k, exp_lsu, k == 3, k == 3);
        end

        // Inputs changed and dropped mid-transaction.
        tick();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0000_0100;
        wait_grant("lsu change", 32'h0000_0100);
        tick();
        lsu_addr     = 32'h0000_0200;
        lsu_wdata    = 32'h1234_5678;
        lsu_reqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clock);
            check("lsu change mem_addr", mem_addr, 32'h0000_0100);
            check("lsu change valid", mem_reqValid, 1'b1);
        end
        serve("lsu change", 1, 32'h0000_CAFE, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while busy on a fetch, then a stale response.
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h0000_3000;
        wait_grant("reset mid", 32'h0000_3000);
        tick();
        #2 reset = 1'b1;
        #1;
        check("reset mid mem_reqValid", mem_reqValid, 1'b0);
        check("reset mid ifu_respValid", ifu_respValid, 1'b0);
        ifu_reqValid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        tick();
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0BAD;
        @(negedge clock);
        check("stale ifu_respValid", ifu_respValid, 1'b0);
        check("stale lsu_respValid", lsu_respValid, 1'b0);
        check("stale ifu_rdata", ifu_rdata, 32'h0);
        $display("[TB] stale response after reset: ifu_respValid=%0b", ifu_respValid);
        tick();
        mem_respValid = 1'b0;
        @(negedge clock);
        check("stale stays idle", mem_reqValid, 1'b0);

        // Spurious response in IDLE.
        tick();
        mem_respValid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        @(negedge clock);
        check("spurious lsu_respValid", lsu_respValid, 1'b0);
        check("spurious lsu_rdata", lsu_rdata, 32'h0);
        check("spurious ifu_rdata", ifu_rdata, 32'h0);
        $display("[TB] spurious response: lsu_respValid=%0b", lsu_respValid);
        tick();
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        @(negedge clock);
        check("spurious stays idle", mem_reqValid, 1'b0);

        tick();
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
